// File: rtl/trace_capture.sv
// Trace capture buffer: arms on request, triggers when ch0 matches trig_val,
// captures multi-channel samples (every cycle or only on change) into a FIFO,
// then lets the host drain the buffer in write order.
module trace_capture #(
  parameter int unsigned W     = 16,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*W-1:0]         ch_in,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     mode,
  input  logic [W-1:0]             trig_val,
  input  logic                     rd_en,
  output logic [NCH*W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = NCH * W;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            mode_q;
  logic [DW-1:0]   last_wr;
  logic [DW-1:0]   mem [DEPTH];

  logic            wr_en;
  logic            rd_fire;
  logic            clr;

  assign state = state_q;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state and write/read/clear strobes; abort beats arm beats everything else
  always_comb begin
    state_nxt = state_q;
    wr_en     = 1'b0;
    rd_fire   = 1'b0;
    clr       = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      clr       = 1'b1;
    end else if (arm) begin
      state_nxt = ARMED;
      clr       = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ARMED: begin
          if (ch_in[W-1:0] == trig_val) begin
            wr_en     = 1'b1;
            state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          if (!full && (!mode_q || (ch_in != last_wr))) wr_en = 1'b1;
          if (wr_en && (count == CW'(DEPTH - 1))) state_nxt = DONE;
        end
        DONE: begin
          if (rd_en && !empty) begin
            rd_fire = 1'b1;
            if (count == CW'(1)) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pointers, occupancy, read port and latched capture mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      mode_q   <= 1'b0;
      last_wr  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      if (!abort) mode_q <= mode;
    end else begin
      rd_valid <= rd_fire;
      if (wr_en) begin
        wr_ptr  <= wr_ptr + AW'(1);
        count   <= count + CW'(1);
        last_wr <= ch_in;
      end
      if (rd_fire) begin
        rd_ptr  <= rd_ptr + AW'(1);
        count   <= count - CW'(1);
        rd_data <= mem[rd_ptr];
      end
    end
  end

  // Capture storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= ch_in;
  end

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture (W=16, NCH=4, DEPTH=8).
module tb_trace_capture;

  localparam int unsigned W     = 16;
  localparam int unsigned NCH   = 4;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*W-1:0]  ch_in;
  logic              arm;
  logic              abort;
  logic              mode;
  logic [W-1:0]      trig_val;
  logic              rd_en;
  logic [NCH*W-1:0]  rd_data;
  logic              rd_valid;
  logic [3:0]        count;
  logic [1:0]        state;
  logic              full;
  logic              empty;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] sb[$];
  logic [63:0] last_rd = '0;

  trace_capture #(.W(W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .arm(arm), .abort(abort),
    .mode(mode), .trig_val(trig_val), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .state(state), .full(full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic [15:0] tv);
    trig_val = tv;
    mode     = m;
    ch_in    = '0;
    arm      = 1'b1;
    step();
    arm = 1'b0;
    check("arm_state", 64'(state), 64'(2'b01));
    check("arm_count", 64'(count), 64'(0));
  endtask

  task automatic read_one(input string tag);
    logic [63:0] exp;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'(1));
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_data"}, rd_data, exp);
      last_rd = exp;
    end
  endtask

  initial begin
    logic [63:0] tab [15];
    logic [15:0] v;
    int nexp;

    rst = 1'b1; ch_in = '0; arm = 1'b0; abort = 1'b0; mode = 1'b0;
    trig_val = '0; rd_en = 1'b0;
    #2;
    check("rst_state", 64'(state), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", rd_data, 64'(0));
    step();
    rst = 1'b0;
    step();

    // Continuous mode: ramp through the trigger, buffer fills and stops
    do_arm(1'b0, 16'h3000);
    nexp = 0;
    for (int i = 0; i < 12; i++) begin
      v = 16'h2FFE + 16'(i);
      ch_in = {v ^ 16'hFFFF, v ^ 16'h5A5A, 16'(i), v};
      if (v >= 16'h3000 && nexp < 8) begin
        sb.push_back(ch_in);
        nexp++;
      end
      step();
      check("m0_count", 64'(count), 64'(nexp));
      if (i == 1) check("m0_pre_trig", 64'(state), 64'(2'b01));
      if (i == 2) check("m0_trig", 64'(state), 64'(2'b10));
    end
    check("m0_done", 64'(state), 64'(2'b11));
    check("m0_full", 64'(full), 64'(1));
    check("m0_empty", 64'(empty), 64'(0));

    // Drain in FIFO order
    for (int k = 0; k < 8; k++) begin
      read_one("m0_rd");
      check("m0_rd_count", 64'(count), 64'(7 - k));
    end
    check("m0_rd_idle", 64'(state), 64'(0));
    step();
    check("m0_rd_pulse", 64'(rd_valid), 64'(0));
    check("m0_rd_empty", 64'(empty), 64'(1));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("m0_rd9_valid", 64'(rd_valid), 64'(0));
    check("m0_rd9_hold", rd_data, last_rd);

    // Change-only mode; mode input flipped after arm must not matter
    do_arm(1'b1, 16'h0031);
    mode = 1'b0;
    ch_in = 64'h30;
    step();
    check("m1_pre_trig", 64'(state), 64'(2'b01));
    tab = '{64'h31, 64'h31, 64'h31, 64'h31, 64'h31,
            64'h0000_0000_0000_0032, 64'h0000_0000_0001_0032,
            64'h0000_0000_0001_0032, 64'h0000_0002_0001_0032,
            64'h0003_0002_0001_0032, 64'h0003_0002_0001_0031,
            64'h0003_0002_0001_0031, 64'h0000_0000_0000_0033,
            64'hFFFF_0000_0000_0033, 64'h0000_0000_0000_1234};
    nexp = 0;
    for (int i = 0; i < 15; i++) begin
      ch_in = tab[i];
      if ((i == 0 || tab[i] != tab[i-1]) && nexp < 8) begin
        sb.push_back(tab[i]);
        nexp++;
      end
      step();
      if (i == 4) check("m1_hold_count", 64'(count), 64'(1));
      if (i == 7) check("m1_repeat_count", 64'(count), 64'(3));
    end
    check("m1_count", 64'(count), 64'(8));
    check("m1_done", 64'(state), 64'(2'b11));
    for (int k = 0; k < 8; k++) read_one("m1_rd");
    check("m1_idle", 64'(state), 64'(0));

    // Asynchronous reset in the middle of a capture
    do_arm(1'b0, 16'h3000);
    for (int i = 0; i < 5; i++) begin
      ch_in = {48'h0, 16'h3000 + 16'(i)};
      step();
    end
    check("rc_count5", 64'(count), 64'(5));
    check("rc_capture", 64'(state), 64'(2'b10));
    #2 rst = 1'b1;
    #1;
    check("rc_async_state", 64'(state), 64'(0));
    check("rc_async_count", 64'(count), 64'(0));
    check("rc_async_rd_data", rd_data, 64'(0));
    #1 rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      ch_in = {48'h0, 16'h3000 + 16'(i)};
      rd_en = 1'b1;
      step();
      check("rc_stay_idle", 64'(state), 64'(0));
      check("rc_no_capture", 64'(count), 64'(0));
      check("rc_no_read", 64'(rd_valid), 64'(0));
    end
    rd_en = 1'b0;

    // rd_en outside DONE, then abort beating arm
    do_arm(1'b0, 16'h3000);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("armed_rd_ignored", 64'(rd_valid), 64'(0));
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    check("abort_arm_state", 64'(state), 64'(0));
    check("abort_arm_count", 64'(count), 64'(0));

    // arm together with rd_en while draining
    do_arm(1'b0, 16'h3000);
    for (int i = 0; i < 8; i++) begin
      ch_in = {16'hA5A5, 16'(i), 16'h0, 16'h3000 + 16'(i)};
      sb.push_back(ch_in);
      step();
    end
    check("ar_done", 64'(state), 64'(2'b11));
    for (int k = 0; k < 5; k++) read_one("ar_rd");
    check("ar_count3", 64'(count), 64'(3));
    ch_in = '0;
    arm = 1'b1;
    rd_en = 1'b1;
    step();
    arm = 1'b0;
    rd_en = 1'b0;
    sb.delete();
    check("ar_state", 64'(state), 64'(2'b01));
    check("ar_count", 64'(count), 64'(0));
    check("ar_rd_valid", 64'(rd_valid), 64'(0));
    check("ar_rd_hold", rd_data, last_rd);
    step();
    check("ar_still_armed", 64'(state), 64'(2'b01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
